// File: rtl/alu_seq_param_if.sv
// Request/result bundle for alu_seq_param: valid/ready operand port in, valid/ready result port out.
// The master side issues requests and consumes results; the slave side is the ALU.
interface alu_seq_param_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             zero;
  logic             op_err;

  modport master (
    output in_valid, a, b, alu_op, out_ready,
    input  in_ready, out_valid, result, overflow, zero, op_err
  );

  modport slave (
    input  in_valid, a, b, alu_op, out_ready,
    output in_ready, out_valid, result, overflow, zero, op_err
  );
endinterface

// File: rtl/alu_seq_param.sv
// Handshaked execute-stage ALU: single-cycle logic/arith/shift/compare ops plus a
// WIDTH-step shift-add multiplier, with a registered result port that holds under backpressure.
module alu_seq_param #(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  alu_seq_param_if.slave bus
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_NOR  = 4'b1101;

  localparam logic [SHW:0] MUL_STEPS = (SHW+1)'(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL_BUSY, DONE} state_t;

  state_t state;

  logic                    accept;
  logic                    is_mul;
  logic                    mul_last;
  logic [SHW-1:0]          sh;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic signed [WIDTH-1:0] res_c;
  logic                    ovf_c;
  logic                    err_c;

  logic [WIDTH-1:0]        mcand_p0;
  logic [WIDTH-1:0]        mplier_p0;
  logic [WIDTH-1:0]        acc_p0;
  logic [SHW:0]            cnt_p0;

  logic [WIDTH-1:0]        res_p1;
  logic                    ovf_p1;
  logic                    zero_p1;
  logic                    err_p1;
  logic                    vld_p1;

  // Signed overflow of x + y given the wrapped sum r (y is already ~b for SUB).
  function automatic logic add_ovf(input logic signed [WIDTH-1:0] x,
                                   input logic signed [WIDTH-1:0] y,
                                   input logic signed [WIDTH-1:0] r);
    return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  function automatic logic [WIDTH-1:0] bool_ext(input logic bit_in);
    return {{(WIDTH-1){1'b0}}, bit_in};
  endfunction

  assign a_s      = bus.a;
  assign b_s      = bus.b;
  assign sh       = bus.b[SHW-1:0];
  assign is_mul   = (bus.alu_op == OP_MUL);
  assign mul_last = (cnt_p0 == MUL_STEPS);

  // out_ready is the only input allowed to reach in_ready combinationally.
  assign bus.in_ready = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    err_c = 1'b0;
    unique case (bus.alu_op)
      OP_AND:  res_c = a_s & b_s;
      OP_OR:   res_c = a_s | b_s;
      OP_ADD: begin
        res_c = a_s + b_s;
        ovf_c = add_ovf(a_s, b_s, res_c);
      end
      OP_SUB: begin
        res_c = a_s - b_s;
        ovf_c = add_ovf(a_s, ~b_s, res_c);
      end
      OP_SLT:  res_c = bool_ext(a_s < b_s);
      OP_SLTU: res_c = bool_ext(bus.a < bus.b);
      OP_NAND: res_c = ~(a_s & b_s);
      OP_NOR:  res_c = ~(a_s | b_s);
      OP_SLL:  res_c = a_s << sh;
      OP_SRL:  res_c = bus.a >> sh;
      OP_SRA:  res_c = a_s >>> sh;
      OP_MUL:  res_c = '0;
      default: err_c = 1'b1;
    endcase
  end

  // Stage p0: multiplier datapath; only meaningful while the FSM sits in MUL_BUSY.
  always_ff @(posedge clk) begin
    if (accept && is_mul) begin
      mcand_p0  <= bus.a;
      mplier_p0 <= bus.b;
      acc_p0    <= '0;
    end else if ((state == MUL_BUSY) && !mul_last) begin
      if (mplier_p0[0]) acc_p0 <= acc_p0 + mcand_p0;
      mcand_p0  <= mcand_p0 << 1;
      mplier_p0 <= mplier_p0 >> 1;
    end
  end

  // Stage p1: FSM and registered result port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt_p0  <= '0;
      vld_p1  <= 1'b0;
      res_p1  <= '0;
      ovf_p1  <= 1'b0;
      zero_p1 <= 1'b0;
      err_p1  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (is_mul) begin
              cnt_p0 <= '0;
              vld_p1 <= 1'b0;
              state  <= MUL_BUSY;
            end else begin
              res_p1  <= res_c;
              ovf_p1  <= ovf_c;
              zero_p1 <= (res_c == '0);
              err_p1  <= err_c;
              vld_p1  <= 1'b1;
              state   <= DONE;
            end
          end else if ((state == DONE) && bus.out_ready) begin
            vld_p1 <= 1'b0;
            state  <= IDLE;
          end
        end
        MUL_BUSY: begin
          if (mul_last) begin
            res_p1  <= acc_p0;
            ovf_p1  <= 1'b0;
            zero_p1 <= (acc_p0 == '0);
            err_p1  <= 1'b0;
            vld_p1  <= 1'b1;
            state   <= DONE;
          end else begin
            cnt_p0 <= cnt_p0 + 1'b1;
          end
        end
        default: begin
          vld_p1 <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.result    = res_p1;
  assign bus.overflow  = ovf_p1;
  assign bus.zero      = zero_p1;
  assign bus.op_err    = err_p1;

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed bench for alu_seq_param: single-cycle ops, flag edge cases, shifts, the
// iterative multiply (with a mid-multiply reset), backpressure and back-to-back throughput.
module tb_alu_seq_param;

  logic clk;
  logic reset;
  int   tests;
  int   failed;

  alu_seq_param_if #(.WIDTH(64)) ifc ();

  alu_seq_param #(.WIDTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one single-cycle op at the next negedge and check the result one edge later.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [63:0] av, input logic [63:0] bv,
                        input logic [63:0] er, input logic eo,
                        input logic ez, input logic ee);
    @(negedge clk);
    chk({tag, ".in_ready"}, 64'(ifc.in_ready), 64'd1);
    ifc.in_valid = 1'b1;
    ifc.alu_op   = op;
    ifc.a        = av;
    ifc.b        = bv;
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    chk({tag, ".out_valid"}, 64'(ifc.out_valid), 64'd1);
    chk({tag, ".result"},    ifc.result,         er);
    chk({tag, ".overflow"},  64'(ifc.overflow),  64'(eo));
    chk({tag, ".zero"},      64'(ifc.zero),      64'(ez));
    chk({tag, ".op_err"},    64'(ifc.op_err),    64'(ee));
  endtask

  initial begin
    int busy;
    int seen;
    int stable;
    tests         = 0;
    failed        = 0;
    reset         = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    ifc.a         = '0;
    ifc.b         = '0;
    ifc.alu_op    = 4'b0000;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst.in_ready",  64'(ifc.in_ready),  64'd1);
    chk("rst.out_valid", 64'(ifc.out_valid), 64'd0);
    chk("rst.result",    ifc.result,         64'd0);
    chk("rst.overflow",  64'(ifc.overflow),  64'd0);
    chk("rst.zero",      64'(ifc.zero),      64'd0);
    chk("rst.op_err",    64'(ifc.op_err),    64'd0);

    run_op("or",   4'b0001, 64'd45, 64'd44, 64'd45, 1'b0, 1'b0, 1'b0);
    run_op("and",  4'b0000, 64'd45, 64'd44, 64'd44, 1'b0, 1'b0, 1'b0);
    run_op("nand", 4'b1100, 64'd45, 64'd44, 64'hFFFF_FFFF_FFFF_FFD3, 1'b0, 1'b0, 1'b0);
    run_op("nor",  4'b1101, 64'd45, 64'd44, 64'hFFFF_FFFF_FFFF_FFD2, 1'b0, 1'b0, 1'b0);
    run_op("add",  4'b0010, 64'd45, 64'd44, 64'd89, 1'b0, 1'b0, 1'b0);

    run_op("sub01", 4'b0110, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run_op("sub00", 4'b0110, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0);
    run_op("slt01", 4'b0111, 64'd0, 64'd1, 64'd1, 1'b0, 1'b0, 1'b0);

    run_op("add_ovf", 4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0);
    run_op("sltu_m1", 4'b1001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 1'b1, 1'b0);
    run_op("slt_m1",  4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0, 1'b0, 1'b0);

    run_op("sra", 4'b0101, 64'h8000_0000_0000_0000, 64'h104, 64'hF800_0000_0000_0000, 1'b0, 1'b0, 1'b0);
    run_op("srl", 4'b0100, 64'h8000_0000_0000_0000, 64'h104, 64'h0800_0000_0000_0000, 1'b0, 1'b0, 1'b0);
    run_op("sll", 4'b0011, 64'h8000_0000_0000_0000, 64'h104, 64'd0, 1'b0, 1'b1, 1'b0);

    // Multiply 45*44: busy for 64 sampled cycles, result 65 edges after accept.
    @(negedge clk);
    chk("mul.in_ready", 64'(ifc.in_ready), 64'd1);
    ifc.in_valid = 1'b1;
    ifc.alu_op   = 4'b1000;
    ifc.a        = 64'd45;
    ifc.b        = 64'd44;
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    busy = 0;
    for (int i = 0; i < 64; i++) begin
      if (!ifc.in_ready && !ifc.out_valid) busy++;
      @(posedge clk);
      #1;
    end
    chk("mul.busy_cycles",    64'(busy),           64'd64);
    chk("mul.out_valid_e64",  64'(ifc.out_valid),  64'd0);
    @(posedge clk);
    #1;
    chk("mul.out_valid_e65",  64'(ifc.out_valid),  64'd1);
    chk("mul.result",         ifc.result,          64'd1980);
    chk("mul.zero",           64'(ifc.zero),       64'd0);
    chk("mul.overflow",       64'(ifc.overflow),   64'd0);

    // Repeat the multiply, then reset at busy cycle 30.
    @(negedge clk);
    ifc.in_valid = 1'b1;
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    chk("mulrst.in_ready_busy", 64'(ifc.in_ready), 64'd0);
    reset = 1'b1;
    #1;
    chk("mulrst.out_valid_rst", 64'(ifc.out_valid), 64'd0);
    chk("mulrst.result_rst",    ifc.result,         64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mulrst.in_ready_after", 64'(ifc.in_ready), 64'd1);
    seen = 0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (ifc.out_valid) seen++;
    end
    chk("mulrst.out_valid_seen", 64'(seen), 64'd0);

    // Backpressure: ADD result must hold for 5 stalled cycles.
    @(negedge clk);
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    ifc.alu_op    = 4'b0010;
    ifc.a         = 64'd100;
    ifc.b         = 64'd23;
    @(posedge clk);
    #1;
    chk("bp.out_valid", 64'(ifc.out_valid), 64'd1);
    stable = 0;
    for (int i = 0; i < 5; i++) begin
      if (ifc.out_valid && !ifc.in_ready && ifc.result == 64'd123) stable++;
      @(posedge clk);
      #1;
    end
    chk("bp.stable_cycles", 64'(stable), 64'd5);
    chk("bp.result_held",   ifc.result,  64'd123);

    // Four back-to-back ORs once the consumer is ready again.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ifc.out_ready = 1'b1;
      ifc.in_valid  = 1'b1;
      ifc.alu_op    = 4'b0001;
      ifc.a         = 64'(i + 1);
      ifc.b         = 64'h10;
      @(posedge clk);
      #1;
      chk($sformatf("b2b%0d.out_valid", i), 64'(ifc.out_valid), 64'd1);
      chk($sformatf("b2b%0d.result", i),    ifc.result,         64'(i + 1) | 64'h10);
    end
    ifc.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b.drain_out_valid", 64'(ifc.out_valid), 64'd0);

    run_op("bad_op", 4'b1111, 64'd45, 64'd44, 64'd0, 1'b0, 1'b1, 1'b1);
    run_op("after_bad", 4'b0010, 64'd1, 64'd1, 64'd2, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/alu_seq_param.md
Name: alu_seq_param

Overview:
- Parametrised, handshaked successor to the combinational 64-bit ALU in the execute stage.
- Operands enter through a valid/ready input port; results leave through a registered valid/ready output port that holds under backpressure.
- Extends the existing op set (AND/OR/ADD/SUB/SLT/NAND/NOR) with shifts, SLTU and an iterative multi-cycle multiply.

Parameters:
- WIDTH, 64, operand/result width in bits (power of two, >=8).
- SHW, $clog2(WIDTH), shift-amount bits taken from b[SHW-1:0].

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand/op request valid.
- in_ready  out  1  block can accept a request this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- alu_op  in  4  operation select.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- overflow  out  1  signed overflow; ADD/SUB only, 0 for every other op.
- zero  out  1  result == 0.
- op_err  out  1  undefined alu_op was issued.

Behaviour:
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NAND, 1101 NOR.
  - New: 0011 SLL, 0100 SRL, 0101 SRA, 1001 SLTU, 1000 MUL (low WIDTH bits of a*b, signedness irrelevant).
  - Any other code: result=0, zero=1, op_err=1, overflow=0. Single-cycle latency.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - overflow = (sign a == sign b') && (sign result != sign a), where b' = b for ADD and ~b for SUB.
  - SLT/SLTU return 1 or 0 zero-extended to WIDTH.
  - Shifts use b[SHW-1:0] only; upper bits of b are ignored.
- FSM states: IDLE, MUL_BUSY, DONE.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Accept happens when in_valid && in_ready at a rising edge.
  - Non-MUL accept: result, flags and out_valid are registered at that edge (1-cycle latency); state goes to DONE.
  - MUL accept: latch a, b; clear accumulator and counter; go to MUL_BUSY.
  - MUL_BUSY: one shift-add step per cycle for WIDTH cycles; in_ready=0.
  - After the last step: result is loaded, out_valid=1, state goes to DONE. out_valid rises WIDTH+1 edges after accept.
  - DONE with out_ready=0: result and flags hold stable; in_ready=0.
  - DONE with out_ready=1 and no new accept: out_valid drops and state goes to IDLE.
  - DONE with out_ready=1 and a simultaneous accept: the new non-MUL result replaces the old one at that edge, so out_valid stays 1 (back-to-back, one result per cycle). A new MUL goes to MUL_BUSY and out_valid drops.
- Reset (any time, including mid-MUL):
  - state=IDLE; out_valid=0; result=0, overflow=0, zero=0, op_err=0.
  - In-flight multiply is discarded.
  - in_ready=1 in the first cycle after reset deasserts.
- in_valid while in_ready=0 is not accepted. The requester must hold a, b and alu_op until accepted.
- No combinational path from a, b or alu_op to any output. The only combinational path is out_ready to in_ready.

Test Plan:
- Reset, then single-cycle ops with a=45, b=44:
  - OR -> 45; AND -> 44; NAND -> 0xFFFF_FFFF_FFFF_FFD3; NOR -> 0xFFFF_FFFF_FFFF_FFD2; ADD -> 89.
  - Each result appears one edge after accept; overflow=0.
- SUB a=0, b=1 -> result all ones, overflow=0, zero=0. SUB a=0, b=0 -> zero=1. SLT a=0, b=1 -> 1.
- Overflow and comparison edge cases:
  - ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> 0x8000_0000_0000_0000, overflow=1.
  - SLTU a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> 0; SLT on the same operands -> 1.
- Shifts on a=0x8000_0000_0000_0000 with b=0x104 (only b[5:0]=4 is used):
  - SRA -> 0xF800_0000_0000_0000; SRL -> 0x0800_0000_0000_0000; SLL -> 0.
- MUL a=45, b=44:
  - in_ready=0 for 64 cycles; out_valid rises exactly 65 edges after accept; result=1980.
  - Assert reset at busy cycle 30 in a repeat run -> out_valid never rises, in_ready=1 after release.
- Backpressure and throughput:
  - Hold out_ready=0 for 5 cycles after an ADD -> result stable, in_ready=0.
  - Then 4 back-to-back ORs with out_ready=1 -> 4 consecutive out_valid cycles.
  - Opcode 1111 -> op_err=1, result=0.
